// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Closes the dynamic branch predictor loop. Fetch pushes each prediction into
//   an in-order queue. When execute resolves the oldest branch, the head entry is
//   compared against the actual outcome. The unit then produces:
//     - a one-cycle BHT update strobe,
//     - a one-cycle flush with a redirect PC on mispredict,
//     - saturating branch and mispredict counters.
//   All results are registered, so they appear one cycle after the resolving cycle.
//
// Ports:
//   i_clk, i_arst_n                         clock, async active-low reset
//   i_pred_valid/idx/taken/pc, o_pred_ready prediction push interface
//   i_res_valid/taken/target                resolution of the oldest branch
//   o_upd_en/addr/taken                     BHT write-back strobe
//   o_flush, o_redirect_pc                  mispredict flush and correct fetch PC
//   o_occupancy                             queued entry count
//   o_branch_cnt, o_mispredict_cnt          saturating statistics
module branch_resolve_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 5,
  parameter int unsigned PC_W  = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       i_clk,
  input  logic                       i_arst_n,
  input  logic                       i_pred_valid,
  input  logic [IDX_W-1:0]           i_pred_idx,
  input  logic                       i_pred_taken,
  input  logic [PC_W-1:0]            i_pred_pc,
  output logic                       o_pred_ready,
  input  logic                       i_res_valid,
  input  logic                       i_res_taken,
  input  logic [PC_W-1:0]            i_res_target,
  output logic                       o_upd_en,
  output logic [IDX_W-1:0]           o_upd_addr,
  output logic                       o_upd_taken,
  output logic                       o_flush,
  output logic [PC_W-1:0]            o_redirect_pc,
  output logic [$clog2(DEPTH):0]     o_occupancy,
  output logic [CNT_W-1:0]           o_branch_cnt,
  output logic [CNT_W-1:0]           o_mispredict_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] Full = OCC_W'(DEPTH);

  logic [IDX_W-1:0] r_q_idx   [DEPTH];
  logic             r_q_taken [DEPTH];
  logic [PC_W-1:0]  r_q_pc    [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [OCC_W-1:0] r_occ;

  logic             r_upd_en, r_upd_taken, r_flush;
  logic [IDX_W-1:0] r_upd_addr;
  logic [PC_W-1:0]  r_redirect_pc;
  logic [CNT_W-1:0] r_branch_cnt, r_mispredict_cnt;

  logic             w_ready, w_push, w_pop, w_mispred;
  logic [OCC_W-1:0] w_occ_nxt;

  // Ready depends only on registered state; the flush cycle refuses pushes.
  assign w_ready   = (r_occ < Full) && !r_flush;
  assign w_push    = i_pred_valid && w_ready;
  assign w_pop     = i_res_valid && (r_occ != '0);
  assign w_mispred = w_pop && (i_res_taken != r_q_taken[r_head]);

  always_comb begin
    w_occ_nxt = r_occ;
    unique case ({w_push, w_pop})
      2'b10:   w_occ_nxt = r_occ + OCC_W'(1);
      2'b01:   w_occ_nxt = r_occ - OCC_W'(1);
      default: w_occ_nxt = r_occ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_idx[i]   <= '0;
        r_q_taken[i] <= 1'b0;
        r_q_pc[i]    <= '0;
      end
      r_head           <= '0;
      r_tail           <= '0;
      r_occ            <= '0;
      r_upd_en         <= 1'b0;
      r_upd_addr       <= '0;
      r_upd_taken      <= 1'b0;
      r_flush          <= 1'b0;
      r_redirect_pc    <= '0;
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      if (w_push) begin
        r_q_idx[r_tail]   <= i_pred_idx;
        r_q_taken[r_tail] <= i_pred_taken;
        r_q_pc[r_tail]    <= i_pred_pc;
      end

      // A mispredict discards every queued entry, including one pushed this cycle.
      if (w_mispred) begin
        r_head <= '0;
        r_tail <= '0;
        r_occ  <= '0;
      end else begin
        if (w_pop)  r_head <= r_head + PTR_W'(1);
        if (w_push) r_tail <= r_tail + PTR_W'(1);
        r_occ <= w_occ_nxt;
      end

      r_upd_en <= w_pop;
      r_flush  <= w_mispred;
      if (w_pop) begin
        r_upd_addr  <= r_q_idx[r_head];
        r_upd_taken <= i_res_taken;
        if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      end
      if (w_mispred) begin
        r_redirect_pc <= i_res_taken ? i_res_target : (r_q_pc[r_head] + PC_W'(4));
        if (r_mispredict_cnt != '1) r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
      end
    end
  end

  assign o_pred_ready     = w_ready;
  assign o_upd_en         = r_upd_en;
  assign o_upd_addr       = r_upd_addr;
  assign o_upd_taken      = r_upd_taken;
  assign o_flush          = r_flush;
  assign o_redirect_pc    = r_redirect_pc;
  assign o_occupancy      = r_occ;
  assign o_branch_cnt     = r_branch_cnt;
  assign o_mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned PC_W  = 64;
  localparam int unsigned CNT_W = 4;  // small so saturation is reachable

  logic             clk;
  logic             arst_n;
  logic             pred_valid;
  logic [IDX_W-1:0] pred_idx;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_pc;
  logic             pred_ready;
  logic             res_valid;
  logic             res_taken;
  logic [PC_W-1:0]  res_target;
  logic             upd_en;
  logic [IDX_W-1:0] upd_addr;
  logic             upd_taken;
  logic             flush;
  logic [PC_W-1:0]  redirect_pc;
  logic [2:0]       occupancy;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  branch_resolve_unit #(
    .DEPTH(DEPTH), .IDX_W(IDX_W), .PC_W(PC_W), .CNT_W(CNT_W)
  ) u_dut (
    .i_clk           (clk),
    .i_arst_n        (arst_n),
    .i_pred_valid    (pred_valid),
    .i_pred_idx      (pred_idx),
    .i_pred_taken    (pred_taken),
    .i_pred_pc       (pred_pc),
    .o_pred_ready    (pred_ready),
    .i_res_valid     (res_valid),
    .i_res_taken     (res_taken),
    .i_res_target    (res_target),
    .o_upd_en        (upd_en),
    .o_upd_addr      (upd_addr),
    .o_upd_taken     (upd_taken),
    .o_flush         (flush),
    .o_redirect_pc   (redirect_pc),
    .o_occupancy     (occupancy),
    .o_branch_cnt    (branch_cnt),
    .o_mispredict_cnt(mispredict_cnt)
  );

  typedef struct {
    logic [IDX_W-1:0] addr;
    logic             taken;
    logic             flush;
    logic [PC_W-1:0]  redir;
    logic [CNT_W-1:0] bcnt;
    logic [CNT_W-1:0] mcnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
  endtask

  task automatic push(input logic [IDX_W-1:0] idx, input logic t, input logic [PC_W-1:0] pc);
    pred_valid = 1'b1;
    pred_idx   = idx;
    pred_taken = t;
    pred_pc    = pc;
  endtask

  // Issue a resolve and queue the hand-computed result expected one cycle later.
  task automatic resolve(input logic rt, input logic [PC_W-1:0] tgt,
                         input logic [IDX_W-1:0] e_addr, input logic e_flush,
                         input logic [PC_W-1:0] e_redir, input int e_b, input int e_m);
    exp_t e;
    res_valid  = 1'b1;
    res_taken  = rt;
    res_target = tgt;
    e.addr  = e_addr;
    e.taken = rt;
    e.flush = e_flush;
    e.redir = e_redir;
    e.bcnt  = CNT_W'(e_b);
    e.mcnt  = CNT_W'(e_m);
    sb.push_back(e);
  endtask

  // Monitor: every update strobe must match the oldest expected result.
  always @(negedge clk) begin
    if (arst_n) begin
      if (flush && !upd_en) begin
        n_cmp++;
        n_err++;
        $display("FAIL flush_without_upd: got flush=1 upd_en=0 at %0t", $time);
      end
      if (upd_en) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_upd: got upd_en=1 addr=%0d expected no update at %0t",
                   upd_addr, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("upd_addr", 64'(upd_addr), 64'(e.addr));
          chk("upd_taken", 64'(upd_taken), 64'(e.taken));
          chk("flush", 64'(flush), 64'(e.flush));
          if (e.flush) chk("redirect_pc", redirect_pc, e.redir);
          chk("branch_cnt", 64'(branch_cnt), 64'(e.bcnt));
          chk("mispredict_cnt", 64'(mispredict_cnt), 64'(e.mcnt));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_upd_en"}, 64'(upd_en), 64'd0);
    chk({tag, "_upd_addr"}, 64'(upd_addr), 64'd0);
    chk({tag, "_upd_taken"}, 64'(upd_taken), 64'd0);
    chk({tag, "_flush"}, 64'(flush), 64'd0);
    chk({tag, "_redirect"}, redirect_pc, 64'd0);
    chk({tag, "_occ"}, 64'(occupancy), 64'd0);
    chk({tag, "_bcnt"}, 64'(branch_cnt), 64'd0);
    chk({tag, "_mcnt"}, 64'(mispredict_cnt), 64'd0);
    chk({tag, "_ready"}, 64'(pred_ready), 64'd1);
  endtask

  initial begin
    arst_n = 1'b1; pred_valid = 1'b0; pred_idx = '0; pred_taken = 1'b0; pred_pc = '0;
    res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
    #2 arst_n = 1'b0;
    #1 chk_all_zero("reset");
    @(posedge clk); @(posedge clk); #1 arst_n = 1'b1;

    // Correct prediction
    push(5'd3, 1'b1, 64'h100); tick();
    resolve(1'b1, 64'h0, 5'd3, 1'b0, 64'h0, 1, 0); tick();
    @(negedge clk) chk("t1_occ", 64'(occupancy), 64'd0);

    // Mispredict not-taken: redirect to pc+4, single-cycle flush
    push(5'd7, 1'b1, 64'h200); tick();
    resolve(1'b0, 64'h0, 5'd7, 1'b1, 64'h204, 2, 1); tick();
    @(negedge clk);
    chk("t2_ready_in_flush", 64'(pred_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("t2_flush_one_cycle", 64'(flush), 64'd0);
    chk("t2_ready_after", 64'(pred_ready), 64'd1);

    // Mispredict taken with concurrent push: queue cleared, 4th push discarded
    push(5'd1, 1'b0, 64'h300); tick();
    push(5'd2, 1'b1, 64'h310); tick();
    push(5'd4, 1'b1, 64'h320); tick();
    @(negedge clk) chk("t3_occ3", 64'(occupancy), 64'd3);
    push(5'd5, 1'b0, 64'h330);
    resolve(1'b1, 64'h80, 5'd1, 1'b1, 64'h80, 3, 2); tick();
    @(negedge clk);
    chk("t3_occ_flush", 64'(occupancy), 64'd0);
    chk("t3_ready_flush", 64'(pred_ready), 64'd0);
    // A resolve in the flush cycle finds the queue empty
    res_valid = 1'b1; res_taken = 1'b1; tick();
    @(negedge clk);
    chk("t3_ready_after", 64'(pred_ready), 64'd1);
    chk("t3_occ_after", 64'(occupancy), 64'd0);
    chk("t3_no_upd", 64'(upd_en), 64'd0);

    // Fill to DEPTH, refuse extra pushes, drain in order
    for (int i = 0; i < 4; i++) begin
      push(IDX_W'(10 + i), 1'b1, 64'h400 + 64'(i * 4)); tick();
    end
    @(negedge clk);
    chk("t4_full_ready", 64'(pred_ready), 64'd0);
    chk("t4_full_occ", 64'(occupancy), 64'd4);
    push(5'd20, 1'b0, 64'h500); tick();
    @(negedge clk) chk("t4_refused_occ", 64'(occupancy), 64'd4);
    // Push while full with a simultaneous pop is still refused
    push(5'd21, 1'b0, 64'h510);
    resolve(1'b1, 64'h0, 5'd10, 1'b0, 64'h0, 4, 2); tick();
    @(negedge clk) chk("t4_full_pop_push", 64'(occupancy), 64'd3);
    resolve(1'b1, 64'h0, 5'd11, 1'b0, 64'h0, 5, 2); tick();
    resolve(1'b1, 64'h0, 5'd12, 1'b0, 64'h0, 6, 2); tick();
    resolve(1'b1, 64'h0, 5'd13, 1'b0, 64'h0, 7, 2); tick();
    @(negedge clk) chk("t4_drained", 64'(occupancy), 64'd0);

    // Resolve with empty queue is ignored
    res_valid = 1'b1; res_taken = 1'b0; tick();
    @(negedge clk);
    chk("t5_empty_upd", 64'(upd_en), 64'd0);
    chk("t5_empty_bcnt", 64'(branch_cnt), 64'd7);
    chk("t5_empty_mcnt", 64'(mispredict_cnt), 64'd2);

    // Async reset mid-stream
    push(5'd8, 1'b1, 64'h600); tick();
    push(5'd9, 1'b1, 64'h604); tick();
    @(negedge clk) chk("t5_occ2", 64'(occupancy), 64'd2);
    resolve(1'b1, 64'h0, 5'd8, 1'b0, 64'h0, 8, 2); tick();
    @(negedge clk);
    #2 arst_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(posedge clk); #1 arst_n = 1'b1;

    // branch_cnt saturation
    for (int i = 0; i < 17; i++) begin
      push(IDX_W'(i), i[0], 64'h1000 + 64'(i * 4)); tick();
      resolve(i[0], 64'h0, IDX_W'(i), 1'b0, 64'h0, (i + 1 > 15) ? 15 : i + 1, 0); tick();
    end
    // mispredict_cnt saturation
    for (int i = 0; i < 17; i++) begin
      push(IDX_W'(i + 1), 1'b0, 64'h2000 + 64'(i * 4)); tick();
      resolve(1'b1, 64'h3000 + 64'(i * 8), IDX_W'(i + 1), 1'b1, 64'h3000 + 64'(i * 8),
              15, (i + 1 > 15) ? 15 : i + 1);
      tick();
      tick();
    end
    // pc+4 wraps modulo 2^PC_W
    push(5'd31, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE); tick();
    resolve(1'b0, 64'h0, 5'd31, 1'b1, 64'h2, 15, 15); tick();
    tick(); tick();
    @(negedge clk);
    chk("sat_bcnt", 64'(branch_cnt), 64'd15);
    chk("sat_mcnt", 64'(mispredict_cnt), 64'd15);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Closing half of the dynamic branch predictor loop. Fetch consults branch_history_table and pushes each prediction into this block's in-order queue.
- When execute resolves the oldest branch, this block compares outcome against prediction and produces:
  - the write-back strobe (en / write_addr / was_taken) into branch_history_table;
  - a pipeline flush with redirect PC on mispredict;
  - saturating statistics counters.

Parameters:
- DEPTH, 4, in-flight branch queue entries (power of 2, ≥2)
- IDX_W, 5, BHT index width (matches 32-entry table)
- PC_W, 64, program counter width
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  system clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- pred_valid  in  1  fetch issued a branch prediction this cycle
- pred_idx  in  IDX_W  BHT index used for that prediction
- pred_taken  in  1  predicted direction
- pred_pc  in  PC_W  PC of the predicted branch
- pred_ready  out  1  queue can accept a push this cycle
- res_valid  in  1  execute resolved the oldest outstanding branch
- res_taken  in  1  actual direction
- res_target  in  PC_W  actual taken target
- upd_en  out  1  BHT update strobe (drives branch_history_table en)
- upd_addr  out  IDX_W  BHT index to update
- upd_taken  out  1  actual outcome (drives was_taken)
- flush  out  1  mispredict flush pulse
- redirect_pc  out  PC_W  correct fetch PC, valid when flush=1
- occupancy  out  $clog2(DEPTH)+1  entries currently queued
- branch_cnt  out  CNT_W  resolved branches, saturating
- mispredict_cnt  out  CNT_W  mispredicted branches, saturating

Behaviour:
- Reset (arst_n=0, asynchronous): all outputs 0 and queue emptied. This includes upd_en, upd_addr, upd_taken, flush, redirect_pc, occupancy and both counters.
- pred_ready = (occupancy < DEPTH) && !flush. Driven from registered state only; no combinational path from pred_valid or res_valid.
- Push: pred_valid && pred_ready stores {pred_idx, pred_taken, pred_pc} at the tail.
- Pop: res_valid && occupancy>0 removes the head.
  - res_valid while empty is ignored: no update, no counter change.
- Simultaneous push and pop in one cycle:
  - occupancy unchanged;
  - a push when full is refused even if a pop happens in the same cycle.
- Pointers wrap modulo DEPTH.
- Resolution latency: exactly 1 cycle. Outputs are registered on the edge that ends the accepting cycle T, and are visible in cycle T+1.
  - upd_en=1 for one cycle, with upd_addr=head.idx and upd_taken=res_taken.
  - upd_en=0 whenever no pop occurred; upd_addr and upd_taken hold their last values.
  - branch_cnt += 1, saturating at 2^CNT_W-1.
- Mispredict: res_taken != head.pred_taken at pop. In cycle T+1:
  - flush=1 for exactly one cycle;
  - mispredict_cnt += 1, saturating;
  - redirect_pc = res_taken ? res_target : head.pc + 4, where +4 wraps modulo 2^PC_W;
  - the whole queue is cleared on the same edge and occupancy=0 in T+1. Entries pushed in cycle T are discarded as wrong-path;
  - pred_ready=0 during T+1, so no push is accepted in the flush cycle;
  - res_valid during T+1 finds the queue empty and is ignored.
- Correct prediction: flush=0 and redirect_pc holds its last value.
- Reset asserted mid-operation overrides everything. Any pending update or flush pulse is dropped.

Test Plan:
- Reset, then push idx=3 taken=1 pc=0x100; resolve res_taken=1 → next cycle upd_en=1, upd_addr=3, upd_taken=1, flush=0, branch_cnt=1, mispredict_cnt=0, occupancy=0.
- Push idx=7 taken=1 pc=0x200; resolve res_taken=0 → next cycle flush=1, redirect_pc=0x204, upd_addr=7, upd_taken=0, mispredict_cnt=1. Flush lasts 1 cycle.
- Push 3 entries; resolve oldest (predicted 0, actual 1, res_target=0x80) while pushing a 4th → flush=1, redirect_pc=0x80, occupancy=0. The 4th push is discarded; pred_ready=0 in the flush cycle and 1 after.
- Push DEPTH=4 entries with no resolves → pred_ready=0 and occupancy=4. A 5th pred_valid is ignored. Resolve 4 correct branches over 4 cycles → upd_addr sequence matches push order, then occupancy=0.
- res_valid with empty queue → upd_en stays 0 and counters unchanged. Pulse arst_n low mid-stream with 2 entries queued → all outputs 0 immediately (asynchronous), queue empty.
- Force branch_cnt to 0xFFFF (or run 2^CNT_W resolves with small CNT_W) → stays at 0xFFFF and does not wrap.
